// File: rtl/wn_pdcchrx_pkg.sv
// -----------------------------------------------------------------------------
// wn_pdcchrx_pkg
// Shared types and constants for the PDCCH-Rx offset-angle repeater.
//   cplx_t    : packed complex sample {imag, re}, DW_DEF bits per component
//   ar_cfg_t  : repeater job configuration {conj, rep_cnt, nrx_m1}
//   state_t   : repeater control states
//   ch_width  : antenna-index width for a given antenna count (never below 1)
// -----------------------------------------------------------------------------
package wn_pdcchrx_pkg;

   localparam int DW_DEF      = 24;
   localparam int NRX_MAX_DEF = 4;
   localparam int REP_W_DEF   = 6;

   // Width of an antenna index; a single-antenna build still needs one bit.
   function automatic int ch_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   localparam int CH_W_DEF = ch_width(NRX_MAX_DEF);

   typedef struct packed {
      logic signed [DW_DEF-1:0] imag;
      logic signed [DW_DEF-1:0] re;
   } cplx_t;

   typedef struct packed {
      logic                  conj;
      logic [REP_W_DEF-1:0]  rep_cnt;
      logic [CH_W_DEF-1:0]   nrx_m1;
   } ar_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/wn_pdcchrx_cplx_conj_sat.sv
// -----------------------------------------------------------------------------
// wn_pdcchrx_cplx_conj_sat
// Combinational optional complex conjugate. The imaginary part is negated with
// saturation (the most negative value maps to the most positive value); the
// real part passes through unchanged.
// Ports:
//   cplx_i  in  2*DW  {imag, real} two's complement
//   conj_i  in  1     1 = conjugate, 0 = pass through
//   cplx_o  out 2*DW  {imag, real} result
// -----------------------------------------------------------------------------
module wn_pdcchrx_cplx_conj_sat #(
   parameter int DW = 24
) (
   input  logic [2*DW-1:0] cplx_i,
   input  logic            conj_i,
   output logic [2*DW-1:0] cplx_o
);

   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

   logic [DW-1:0] re_s;
   logic [DW-1:0] im_s;
   logic [DW-1:0] im_out_s;

   assign re_s = cplx_i[DW-1:0];
   assign im_s = cplx_i[2*DW-1:DW];

   // Negate the imaginary part when conjugating, clamping the one overflow case.
   always_comb begin
      im_out_s = im_s;
      if (!conj_i) begin
         im_out_s = im_s;
      end else if (im_s == MOST_NEG) begin
         im_out_s = MOST_POS;
      end else begin
         im_out_s = (~im_s) + {{(DW-1){1'b0}}, 1'b1};
      end
   end

   assign cplx_o = {im_out_s, re_s};

endmodule

// File: rtl/wn_pdcchrx_offset_angle_repeater_mc.sv
// -----------------------------------------------------------------------------
// wn_pdcchrx_offset_angle_repeater_mc
// Multi-antenna offset-angle repeater. Each accepted phasor is emitted REP
// times and each repetition once per active Rx antenna (antenna index inner,
// repetition outer), optionally conjugated. The output is a single register
// stage, so the first beat appears the cycle after the input handshake and the
// next phasor can be loaded on the same edge the final beat is accepted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   config_in_*       AXIS config {conj, rep_cnt, nrx_m1}; accepted in IDLE only
//   data_in_*         AXIS phasor {imag, real}; tlast marks last phasor of job
//   data_out_*        AXIS beats {imag, real}; tuser = antenna index,
//                     tlast = final beat of the job
// -----------------------------------------------------------------------------
module wn_pdcchrx_offset_angle_repeater_mc
   import wn_pdcchrx_pkg::*;
#(
   parameter  int DW      = DW_DEF,
   parameter  int NRX_MAX = NRX_MAX_DEF,
   parameter  int REP_W   = REP_W_DEF,
   localparam int CH_W    = ch_width(NRX_MAX)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REP_W+CH_W:0]     config_in_tdata,
   input  logic                    config_in_tvalid,
   output logic                    config_in_tready,
   input  logic [2*DW-1:0]         data_in_tdata,
   input  logic                    data_in_tvalid,
   output logic                    data_in_tready,
   input  logic                    data_in_tlast,
   output logic [2*DW-1:0]         data_out_tdata,
   output logic [CH_W-1:0]         data_out_tuser,
   output logic                    data_out_tvalid,
   input  logic                    data_out_tready,
   output logic                    data_out_tlast
);

   localparam logic [CH_W-1:0] NRX_LAST_MAX = CH_W'(NRX_MAX - 1);

   state_t            state_q,     state_d;
   logic              cfg_rdy_q,   cfg_rdy_d;
   logic              conj_q,      conj_d;
   logic [REP_W-1:0]  rep_last_q,  rep_last_d;
   logic [CH_W-1:0]   nrx_last_q,  nrx_last_d;
   logic [REP_W-1:0]  rep_ctr_q,   rep_ctr_d;
   logic [CH_W-1:0]   ch_cnt_q,    ch_cnt_d;
   logic              job_last_q,  job_last_d;
   logic              out_valid_q, out_valid_d;
   logic [2*DW-1:0]   out_data_q,  out_data_d;

   logic              cfg_conj_s;
   logic [REP_W-1:0]  cfg_rep_s;
   logic [CH_W-1:0]   cfg_nrx_s;
   logic              cfg_hs_s;
   logic              in_rdy_s;
   logic              in_hs_s;
   logic              out_hs_s;
   logic              last_beat_s;
   logic [2*DW-1:0]   conj_data_s;

   assign cfg_nrx_s  = config_in_tdata[CH_W-1:0];
   assign cfg_rep_s  = config_in_tdata[REP_W+CH_W-1:CH_W];
   assign cfg_conj_s = config_in_tdata[REP_W+CH_W];

   // Last beat of the current sample: both counters at their terminal values.
   assign last_beat_s = (rep_ctr_q == rep_last_q) && (ch_cnt_q == nrx_last_q);
   assign out_hs_s    = out_valid_q && data_out_tready;
   assign cfg_hs_s    = config_in_tvalid && cfg_rdy_q;
   // In EMIT the next phasor is only pulled when the final beat of this one
   // leaves on this edge and the job continues, giving back-to-back output.
   assign in_rdy_s    = (state_q == ST_LOAD) ||
                        ((state_q == ST_EMIT) && last_beat_s && data_out_tready && !job_last_q);
   assign in_hs_s     = data_in_tvalid && in_rdy_s;

   wn_pdcchrx_cplx_conj_sat #(
      .DW (DW)
   ) u_conj_sat (
      .cplx_i (data_in_tdata),
      .conj_i (conj_q),
      .cplx_o (conj_data_s)
   );

   // Next-state logic: control FSM, config capture, counters and output register.
   always_comb begin
      state_d     = state_q;
      conj_d      = conj_q;
      rep_last_d  = rep_last_q;
      nrx_last_d  = nrx_last_q;
      rep_ctr_d   = rep_ctr_q;
      ch_cnt_d    = ch_cnt_q;
      job_last_d  = job_last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_hs_s) begin
               conj_d = cfg_conj_s;
               // REP of zero behaves as one repetition.
               if (cfg_rep_s == {REP_W{1'b0}}) begin
                  rep_last_d = {REP_W{1'b0}};
               end else begin
                  rep_last_d = cfg_rep_s - REP_W'(1);
               end
               if (int'(cfg_nrx_s) > (NRX_MAX - 1)) begin
                  nrx_last_d = NRX_LAST_MAX;
               end else begin
                  nrx_last_d = cfg_nrx_s;
               end
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (in_hs_s) begin
               out_data_d  = conj_data_s;
               job_last_d  = data_in_tlast;
               rep_ctr_d   = {REP_W{1'b0}};
               ch_cnt_d    = {CH_W{1'b0}};
               out_valid_d = 1'b1;
               state_d     = ST_EMIT;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_EMIT: begin
            if (!out_hs_s) begin
               state_d = ST_EMIT;
            end else if (!last_beat_s) begin
               if (ch_cnt_q == nrx_last_q) begin
                  ch_cnt_d  = {CH_W{1'b0}};
                  rep_ctr_d = rep_ctr_q + REP_W'(1);
               end else begin
                  ch_cnt_d  = ch_cnt_q + CH_W'(1);
               end
            end else if (job_last_q) begin
               rep_ctr_d   = {REP_W{1'b0}};
               ch_cnt_d    = {CH_W{1'b0}};
               job_last_d  = 1'b0;
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (in_hs_s) begin
               out_data_d  = conj_data_s;
               job_last_d  = data_in_tlast;
               rep_ctr_d   = {REP_W{1'b0}};
               ch_cnt_d    = {CH_W{1'b0}};
               out_valid_d = 1'b1;
               state_d     = ST_EMIT;
            end else begin
               rep_ctr_d   = {REP_W{1'b0}};
               ch_cnt_d    = {CH_W{1'b0}};
               out_valid_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         default: begin
            rep_ctr_d   = {REP_W{1'b0}};
            ch_cnt_d    = {CH_W{1'b0}};
            job_last_d  = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      // Registered ready keeps config_in_tready low through reset itself.
      cfg_rdy_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cfg_rdy_q   <= 1'b0;
         conj_q      <= 1'b0;
         rep_last_q  <= {REP_W{1'b0}};
         nrx_last_q  <= {CH_W{1'b0}};
         rep_ctr_q   <= {REP_W{1'b0}};
         ch_cnt_q    <= {CH_W{1'b0}};
         job_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {(2*DW){1'b0}};
      end else begin
         state_q     <= state_d;
         cfg_rdy_q   <= cfg_rdy_d;
         conj_q      <= conj_d;
         rep_last_q  <= rep_last_d;
         nrx_last_q  <= nrx_last_d;
         rep_ctr_q   <= rep_ctr_d;
         ch_cnt_q    <= ch_cnt_d;
         job_last_q  <= job_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign config_in_tready = cfg_rdy_q;
   assign data_in_tready   = in_rdy_s;
   assign data_out_tdata   = out_data_q;
   assign data_out_tuser   = ch_cnt_q;
   assign data_out_tvalid  = out_valid_q;
   assign data_out_tlast   = out_valid_q && job_last_q && last_beat_s;

endmodule

// File: tb/tb_wn_pdcchrx_offset_angle_repeater_mc.sv
// -----------------------------------------------------------------------------
// Directed testbench for wn_pdcchrx_offset_angle_repeater_mc. Output beats are
// collected as {tlast, tuser, imag, real} words and compared against
// hand-computed expected beats.
// -----------------------------------------------------------------------------
module tb_wn_pdcchrx_offset_angle_repeater_mc;
   import wn_pdcchrx_pkg::*;

   logic        clk;
   logic        rst;
   logic [8:0]  config_in_tdata;
   logic        config_in_tvalid;
   logic        config_in_tready;
   logic [47:0] data_in_tdata;
   logic        data_in_tvalid;
   logic        data_in_tready;
   logic        data_in_tlast;
   logic [47:0] data_out_tdata;
   logic [1:0]  data_out_tuser;
   logic        data_out_tvalid;
   logic        data_out_tready;
   logic        data_out_tlast;

   int          err_cnt   = 0;
   int          check_cnt = 0;
   logic        rand_ready = 1'b0;
   logic        rand_in    = 1'b0;
   int          cur_run = 0;
   int          max_run = 0;
   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];

   wn_pdcchrx_offset_angle_repeater_mc dut (
      .clk              (clk),
      .rst              (rst),
      .config_in_tdata  (config_in_tdata),
      .config_in_tvalid (config_in_tvalid),
      .config_in_tready (config_in_tready),
      .data_in_tdata    (data_in_tdata),
      .data_in_tvalid   (data_in_tvalid),
      .data_in_tready   (data_in_tready),
      .data_in_tlast    (data_in_tlast),
      .data_out_tdata   (data_out_tdata),
      .data_out_tuser   (data_out_tuser),
      .data_out_tvalid  (data_out_tvalid),
      .data_out_tready  (data_out_tready),
      .data_out_tlast   (data_out_tlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] beat(input logic last, input logic [1:0] user,
                                        input logic [23:0] im, input logic [23:0] re);
      return {13'd0, last, user, im, re};
   endfunction

   // Output ready: always high, or randomly throttled.
   initial begin
      data_out_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) data_out_tready = ($urandom_range(0, 9) > 3);
         else            data_out_tready = 1'b1;
      end
   end

   // Output monitor: collects beats, checks stability under stall, tracks valid runs.
   initial begin
      logic        prev_stall;
      logic [63:0] prev_beat;
      logic [63:0] cur_beat;
      prev_stall = 1'b0;
      prev_beat  = 64'd0;
      forever begin
         @(negedge clk);
         cur_beat = {13'd0, data_out_tlast, data_out_tuser, data_out_tdata};
         if (rst) begin
            prev_stall = 1'b0;
            cur_run    = 0;
         end else begin
            if (prev_stall) begin
               check_eq("stall_valid", {63'd0, data_out_tvalid}, 64'd1);
               check_eq("stall_beat", cur_beat, prev_beat);
            end
            if (data_out_tvalid && data_out_tready) got_q.push_back(cur_beat);
            prev_stall = data_out_tvalid && !data_out_tready;
            prev_beat  = cur_beat;
            if (data_out_tvalid) cur_run++;
            else                 cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
         end
      end
   end

   task automatic rand_stall();
      if (rand_in) begin
         repeat ($urandom_range(0, 9)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_cfg(input logic conj, input int rep, input int nrx_m1);
      ar_cfg_t c;
      logic    hs;
      int      cyc;
      c.conj    = conj;
      c.rep_cnt = 6'(rep);
      c.nrx_m1  = 2'(nrx_m1);
      rand_stall();
      config_in_tdata  = c;
      config_in_tvalid = 1'b1;
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 1000) begin
         @(negedge clk);
         hs = config_in_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!hs) check_eq("cfg_timeout", 64'd0, 64'd1);
      config_in_tvalid = 1'b0;
   endtask

   task automatic send_data(input logic [23:0] re, input logic [23:0] im, input logic last);
      cplx_t p;
      logic  hs;
      int    cyc;
      p.re = re;
      p.imag = im;
      rand_stall();
      data_in_tdata  = p;
      data_in_tlast  = last;
      data_in_tvalid = 1'b1;
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 1000) begin
         @(negedge clk);
         hs = data_in_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!hs) check_eq("data_timeout", 64'd0, 64'd1);
      data_in_tvalid = 1'b0;
      data_in_tlast  = 1'b0;
   endtask

   // Wait for the expected beat count (bounded), settle, then compare beat by beat.
   task automatic finish_job(input string tag);
      int cyc;
      int n;
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      repeat (10) @(posedge clk);
      #1;
      check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      config_in_tdata  = 9'd0;
      config_in_tvalid = 1'b0;
      data_in_tdata    = 48'd0;
      data_in_tvalid   = 1'b0;
      data_in_tlast    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cfg_rdy",  {63'd0, config_in_tready}, 64'd0);
      check_eq("rst_in_rdy",   {63'd0, data_in_tready},   64'd0);
      check_eq("rst_valid",    {63'd0, data_out_tvalid},  64'd0);
      check_eq("rst_last",     {63'd0, data_out_tlast},   64'd0);
      check_eq("rst_data",     {16'd0, data_out_tdata},   64'd0);
      check_eq("rst_user",     {62'd0, data_out_tuser},   64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("cfg_rdy_pre",  {63'd0, config_in_tready}, 64'd0);
      @(negedge clk);
      check_eq("cfg_rdy_post", {63'd0, config_in_tready}, 64'd1);
      @(posedge clk);
      #1;

      // Full rate: REP=1, NRX=1, eight back-to-back phasors
      for (int i = 0; i < 8; i++) exp_q.push_back(beat(i == 7, 2'd0, 24'h000200 + 24'(i), 24'h000100 + 24'(i)));
      max_run = 0;
      send_cfg(1'b0, 1, 0);
      for (int i = 0; i < 8; i++) send_data(24'h000100 + 24'(i), 24'h000200 + 24'(i), i == 7);
      finish_job("fullrate");
      check_eq("fullrate_run", 64'(max_run), 64'd8);

      // Repeat + fanout: REP=3, NRX=2, one phasor
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(i == 5, 2'(i % 2), 24'h00ABCD, 24'h123456));
      send_cfg(1'b0, 3, 1);
      send_data(24'h123456, 24'h00ABCD, 1'b1);
      finish_job("repfan");

      // Conjugate with saturation
      exp_q.push_back(beat(1'b0, 2'd0, 24'h7FFFFF, 24'h000001));
      exp_q.push_back(beat(1'b1, 2'd0, 24'hFFFFF0, 24'h000002));
      send_cfg(1'b1, 1, 0);
      send_data(24'h000001, 24'h800000, 1'b0);
      send_data(24'h000002, 24'h000010, 1'b1);
      finish_job("conj");

      // rep_cnt=0 behaves as REP=1, NRX=4
      for (int i = 0; i < 8; i++) exp_q.push_back(beat(i == 7, 2'(i % 4), 24'h0000AA + 24'(i / 4), 24'h000055));
      send_cfg(1'b0, 0, 3);
      send_data(24'h000055, 24'h0000AA, 1'b0);
      send_data(24'h000055, 24'h0000AB, 1'b1);
      finish_job("rep0");

      // Throttled: conj, REP=2, NRX=3, random stalls everywhere
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(1'b0, 2'(i % 3), 24'hFFFFFB, 24'h111111));
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(1'b0, 2'(i % 3), 24'h000002, 24'hABCDEF));
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(i == 5, 2'(i % 3), 24'h800001, 24'h000000));
      rand_ready = 1'b1;
      rand_in    = 1'b1;
      send_cfg(1'b1, 2, 2);
      send_data(24'h111111, 24'h000005, 1'b0);
      send_data(24'hABCDEF, 24'hFFFFFE, 1'b0);
      send_data(24'h000000, 24'h7FFFFF, 1'b1);
      finish_job("throttle");
      rand_ready = 1'b0;
      rand_in    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset after the 3rd of 6 beats
      begin
         int cyc;
         send_cfg(1'b0, 3, 1);
         send_data(24'h0F0F0F, 24'h00F00F, 1'b1);
         cyc = 0;
         while (got_q.size() < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
         end
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         check_eq("midrst_valid",   {63'd0, data_out_tvalid},  64'd0);
         check_eq("midrst_cfg_rdy", {63'd0, config_in_tready}, 64'd0);
         @(negedge clk);
         check_eq("midrst_cfg_rdy2", {63'd0, config_in_tready}, 64'd1);
         check_eq("midrst_valid2",   {63'd0, data_out_tvalid},  64'd0);
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) exp_q.push_back(beat(1'b0, 2'(i % 2), 24'h00F00F, 24'h0F0F0F));
         finish_job("midrst");
      end

      // Job after reset is complete from its first beat
      for (int i = 0; i < 2; i++) exp_q.push_back(beat(i == 1, 2'(i), 24'h000777, 24'h000333));
      send_cfg(1'b0, 1, 1);
      send_data(24'h000333, 24'h000777, 1'b1);
      finish_job("postrst");

      $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
      $finish;
   end

endmodule
